// File: rtl/exec_commit.sv
// Execute/commit stage: retires one ALU result per cycle into the register file, PC or flags,
// and runs single-outstanding LD/ST memory transactions with a load writeback cycle.
module exec_commit #(
  parameter logic [2:0] RD_SP = 3'd7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] ir,
  input  logic [31:0] dr,
  input  logic [31:0] tr,
  input  logic        sf,
  input  logic        zf,
  input  logic        cf,
  input  logic        vf,
  input  logic        flag_up,
  output logic [3:0]  flags,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        pc_we,
  output logic [31:0] pc_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // Opcode byte lives in ir[31:24]; the whole 8'hFx range is Bcc with the condition in ir[27:24].
  localparam logic [7:0] Z_LIL  = 8'h01, Z_MOV  = 8'h02, Z_ADD  = 8'h03, Z_SUB  = 8'h04;
  localparam logic [7:0] Z_AND  = 8'h05, Z_OR   = 8'h06, Z_XOR  = 8'h07, Z_ADDI = 8'h08;
  localparam logic [7:0] Z_SUBI = 8'h09, Z_ANDI = 8'h0A, Z_ORI  = 8'h0B, Z_XORI = 8'h0C;
  localparam logic [7:0] Z_NEG  = 8'h0D, Z_NOT  = 8'h0E, Z_SLL  = 8'h0F, Z_SLA  = 8'h10;
  localparam logic [7:0] Z_SRL  = 8'h11, Z_SRA  = 8'h12;
  localparam logic [7:0] Z_JALR = 8'h20, Z_RET  = 8'h21, Z_PUSH = 8'h22, Z_POP  = 8'h23;
  localparam logic [7:0] Z_CMP  = 8'h30, Z_CMPI = 8'h31;
  localparam logic [7:0] Z_B    = 8'h40, Z_JR   = 8'h41;
  localparam logic [7:0] Z_LD   = 8'h50, Z_ST   = 8'h51;
  localparam logic [3:0] Z_BCC  = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_LDWB} state_t;

  state_t      state_q, state_d;
  logic [3:0]  flags_q, flags_d;
  logic        rf_we_q, rf_we_d, pc_we_q, pc_we_d;
  logic [2:0]  rf_waddr_q, rf_waddr_d, rd_q, rd_d;
  logic [31:0] rf_wdata_q, rf_wdata_d, pc_wdata_q, pc_wdata_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [7:0]  op;
  logic        accept;
  logic        unused_ir;

  // flags are packed {S,Z,C,V}; codes 12-15 are reserved and never taken
  function automatic logic cond_true(input logic [3:0] cc, input logic [3:0] f);
    logic s, z, c, v;
    {s, z, c, v} = f;
    case (cc)
      4'd0:    cond_true = z;
      4'd1:    cond_true = !z;
      4'd2:    cond_true = s ^ v;
      4'd3:    cond_true = (s ^ v) | z;
      4'd4:    cond_true = !(s ^ v);
      4'd5:    cond_true = !(s ^ v) & !z;
      4'd6:    cond_true = c;
      4'd7:    cond_true = !c;
      4'd8:    cond_true = s;
      4'd9:    cond_true = !s;
      4'd10:   cond_true = v;
      4'd11:   cond_true = !v;
      default: cond_true = 1'b0;
    endcase
  endfunction

  assign op        = ir[31:24];
  assign unused_ir = ^{ir[23:19], ir[15:0]};
  assign in_ready  = rst_n & (state_q == S_IDLE);
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    rf_we_d     = 1'b0;
    pc_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    pc_wdata_d  = pc_wdata_q;
    rd_d        = rd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (flag_up) flags_d = {sf, zf, cf, vf};
          if (op == Z_LD || op == Z_ST) begin
            state_d    = S_MEM;
            mem_req_d  = 1'b1;
            mem_addr_d = dr;
            mem_we_d   = (op == Z_ST);
            rd_d       = ir[18:16];
            if (op == Z_ST) mem_wdata_d = tr;
          end else if (op inside {Z_LIL, Z_MOV, Z_ADD, Z_SUB, Z_AND, Z_OR, Z_XOR, Z_ADDI,
                                  Z_SUBI, Z_ANDI, Z_ORI, Z_XORI, Z_NEG, Z_NOT, Z_SLL,
                                  Z_SLA, Z_SRL, Z_SRA}) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = ir[18:16];
            rf_wdata_d = dr;
          end else if (op inside {Z_JALR, Z_RET, Z_PUSH, Z_POP}) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = RD_SP;
            rf_wdata_d = dr;
          end else if (op == Z_B || op == Z_JR ||
                       (op[7:4] == Z_BCC && cond_true(op[3:0], flags_q))) begin
            // Bcc tests the flags from before this instruction, not the ones it may load
            pc_we_d    = 1'b1;
            pc_wdata_d = dr;
          end
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (mem_we_q) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_LDWB;
            rf_we_d    = 1'b1;
            rf_waddr_d = rd_q;
            rf_wdata_d = mem_rdata;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      flags_q     <= '0;
      rf_we_q     <= 1'b0;
      pc_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      pc_wdata_q  <= '0;
      rd_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      rf_we_q     <= rf_we_d;
      pc_we_q     <= pc_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      pc_wdata_q  <= pc_wdata_d;
      rd_q        <= rd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign flags     = flags_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign pc_we     = pc_we_q;
  assign pc_wdata  = pc_wdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_exec_commit.sv
// Bench for exec_commit: directed scenarios followed by random instruction/memory traffic,
// checked against a transaction-level model of commit effects and architectural flags.
module tb_exec_commit;

  localparam logic [7:0] O_LIL = 8'h01, O_ADD = 8'h03, O_CMP = 8'h30, O_PUSH = 8'h22;
  localparam logic [7:0] O_B = 8'h40, O_JR = 8'h41, O_LD = 8'h50, O_ST = 8'h51;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] ir, dr, tr;
  logic        sf, zf, cf, vf, flag_up;
  logic [3:0]  flags;
  logic        rf_we, pc_we, mem_req, mem_we, mem_ack;
  logic [2:0]  rf_waddr;
  logic [31:0] rf_wdata, pc_wdata, mem_addr, mem_wdata, mem_rdata;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [3:0]  exp_flags = 4'h0;

  // Opcodes that write the register named in ir[18:16], and those that write the stack pointer (7)
  logic [7:0]  rd_ops[$] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
                             8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h11, 8'h12};
  logic [7:0]  sp_ops[$] = '{8'h20, 8'h21, 8'h22, 8'h23};

  exec_commit #(.RD_SP(3'd7)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ir(ir), .dr(dr), .tr(tr), .sf(sf), .zf(zf), .cf(cf), .vf(vf), .flag_up(flag_up),
    .flags(flags), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc_we(pc_we), .pc_wdata(pc_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_list(input logic [7:0] op, input logic [7:0] lst[$]);
    foreach (lst[i]) if (lst[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Branch condition table over f = {S,Z,C,V}
  function automatic bit taken(input logic [3:0] cc, input logic [3:0] f);
    bit s, z, c, v;
    s = f[3]; z = f[2]; c = f[1]; v = f[0];
    if (cc == 0) return z;
    if (cc == 1) return !z;
    if (cc == 2) return s != v;
    if (cc == 3) return (s != v) || z;
    if (cc == 4) return s == v;
    if (cc == 5) return (s == v) && !z;
    if (cc == 6) return c;
    if (cc == 7) return !c;
    if (cc == 8) return s;
    if (cc == 9) return !s;
    if (cc == 10) return v;
    if (cc == 11) return !v;
    return 1'b0;
  endfunction

  task automatic issue(input logic [7:0] op, input logic [2:0] rd, input logic [31:0] d,
                       input logic [3:0] fl, input logic fu);
    bit wr, sp, br;
    in_valid = 1'b1;
    ir = {op, 5'($urandom), rd, 16'($urandom)};
    dr = d; tr = $urandom;
    {sf, zf, cf, vf} = fl; flag_up = fu;
    chk("ready_before_issue", 32'(in_ready), 32'd1);
    wr = in_list(op, rd_ops);
    sp = in_list(op, sp_ops);
    br = (op == O_B) || (op == O_JR) || (op[7:4] == 4'hF && taken(op[3:0], exp_flags));
    if (fu) exp_flags = fl;
    tick();
    chk("rf_we", 32'(rf_we), 32'(wr | sp));
    if (wr | sp) begin
      chk("rf_waddr", 32'(rf_waddr), sp ? 32'd7 : 32'(rd));
      chk("rf_wdata", rf_wdata, d);
    end
    chk("pc_we", 32'(pc_we), 32'(br));
    if (br) chk("pc_wdata", pc_wdata, d);
    chk("flags", 32'(flags), 32'(exp_flags));
    chk("mem_req_nonmem", 32'(mem_req), 32'd0);
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    ir = $urandom; flag_up = 1'b1; {sf, zf, cf, vf} = 4'($urandom);
    tick();
    chk("idle_rf_we", 32'(rf_we), 32'd0);
    chk("idle_pc_we", 32'(pc_we), 32'd0);
    chk("idle_flags", 32'(flags), 32'(exp_flags));
  endtask

  task automatic mem_op(input bit st, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdat, input logic [2:0] rd, input int nreq,
                        input logic [3:0] fl, input logic fu);
    in_valid = 1'b1;
    ir = {(st ? O_ST : O_LD), 5'($urandom), rd, 16'($urandom)};
    dr = a; tr = wd; {sf, zf, cf, vf} = fl; flag_up = fu;
    chk("ready_before_mem", 32'(in_ready), 32'd1);
    if (fu) exp_flags = fl;
    tick();
    // Offer a competing ADD with flag update while busy; it must be ignored
    ir = {O_ADD, 5'd0, 3'd1, 16'd0}; dr = $urandom; flag_up = 1'b1;
    {sf, zf, cf, vf} = ~exp_flags;
    for (int k = 0; k < nreq; k++) begin
      mem_ack = (k == nreq - 1);
      mem_rdata = (k == nreq - 1) ? rdat : $urandom;
      chk("mem_req", 32'(mem_req), 32'd1);
      chk("mem_addr", mem_addr, a);
      chk("mem_we", 32'(mem_we), 32'(st));
      if (st) chk("mem_wdata", mem_wdata, wd);
      chk("busy_ready", 32'(in_ready), 32'd0);
      chk("busy_rf_we", 32'(rf_we), 32'd0);
      chk("busy_flags", 32'(flags), 32'(exp_flags));
      tick();
    end
    mem_ack = 1'b0;
    in_valid = 1'b0;
    if (!st) begin
      chk("ld_rf_we", 32'(rf_we), 32'd1);
      chk("ld_rf_waddr", 32'(rf_waddr), 32'(rd));
      chk("ld_rf_wdata", rf_wdata, rdat);
      chk("ld_req_low", 32'(mem_req), 32'd0);
      chk("ldwb_ready", 32'(in_ready), 32'd0);
      tick();
    end
    chk("post_mem_ready", 32'(in_ready), 32'd1);
    chk("post_mem_rf_we", 32'(rf_we), 32'd0);
    chk("post_mem_req", 32'(mem_req), 32'd0);
    chk("post_mem_pc_we", 32'(pc_we), 32'd0);
  endtask

  initial begin
    logic [7:0] op;
    int r;
    rst_n = 1'b0; in_valid = 1'b0; ir = '0; dr = '0; tr = '0;
    {sf, zf, cf, vf} = 4'h0; flag_up = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_pc_we", 32'(pc_we), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_pc_wdata", pc_wdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_release", 32'(in_ready), 32'd1);

    // ADD r2 <- 5 with flags {S,Z,C,V} = 0010
    issue(O_ADD, 3'd2, 32'h5, 4'b0010, 1'b1);
    idle_cycle();
    // CMP sets Z, then Bcc EQ taken / Bcc NE not taken, back-to-back
    issue(O_CMP, 3'd3, 32'h0, 4'b0100, 1'b1);
    issue({4'hF, 4'd0}, 3'd0, 32'h100, 4'h0, 1'b0);
    issue(O_CMP, 3'd3, 32'h0, 4'b0100, 1'b1);
    issue({4'hF, 4'd1}, 3'd0, 32'h100, 4'h0, 1'b0);
    idle_cycle();
    // PUSH leaves flags untouched
    issue(O_PUSH, 3'd4, 32'hFFC, 4'b1111, 1'b0);
    issue(O_B, 3'd0, 32'h2000, 4'h0, 1'b0);
    issue(8'h77, 3'd5, 32'hABCD, 4'h0, 1'b0);
    idle_cycle();
    mem_op(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 3'd6, 3, 4'h0, 1'b0);
    mem_op(1'b1, 32'h80, 32'h1234, 32'h0, 3'd1, 1, 4'h0, 1'b0);

    // Reset in the middle of a load wait
    issue(O_LIL, 3'd1, 32'h1, 4'b1011, 1'b1);
    in_valid = 1'b1; ir = {O_LD, 5'd0, 3'd5, 16'd0}; dr = 32'h40; flag_up = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("abort_req_before", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    exp_flags = 4'h0;
    chk("abort_req_dropped", 32'(mem_req), 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd0);
    chk("abort_rf_we", 32'(rf_we), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      mem_ack = 1'b0;
      chk("abort_no_rf_we", 32'(rf_we), 32'd0);
      chk("abort_no_req", 32'(mem_req), 32'd0);
      chk("abort_ready_back", 32'(in_ready), 32'd1);
    end

    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        mem_op(1'($urandom), $urandom, $urandom, $urandom, 3'($urandom),
               $urandom_range(1, 4), 4'($urandom), 1'($urandom));
      end else if (r == 2) begin
        idle_cycle();
      end else begin
        case ($urandom_range(0, 5))
          0, 1:    op = rd_ops[$urandom_range(0, rd_ops.size() - 1)];
          2:       op = sp_ops[$urandom_range(0, sp_ops.size() - 1)];
          3:       op = {4'hF, 4'($urandom)};
          4:       op = 8'($urandom_range(8'h30, 8'h41));
          default: op = 8'($urandom_range(8'h60, 8'hEF));
        endcase
        if (op > 8'h31 && op < 8'h40) op = O_JR;
        issue(op, 3'($urandom), $urandom, 4'($urandom), 1'($urandom));
      end
    end
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
